vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator. It is the successor to the horizontal-only sync counter. One counter pair produces horizontal and vertical sync, the active-video enable, pixel column/row coordinates and line/frame markers. Porches, sync widths and sync polarities are configurable. A pixel-clock enable allows a faster system clock. It sits between the clock source and the pixel/RGB output stage of the VGA controller.

---
 rtl/vga_timing_gen.sv | 63 ++++++
 tb/tb_vga_timing_gen.sv | 85 ++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with registered syncs/enable and pixel-clock enable
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          rgb_en,
  output logic [CW-1:0] column,
  output logic [CW-1:0] row,
  output logic          line_end,
  output logic          frame_end
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic [CW-1:0] h_cnt, v_cnt, h_nx, v_nx;
  logic          h_wrap, v_wrap;
  always_comb begin
    h_wrap = h_cnt == H_LAST;
    v_wrap = v_cnt == V_LAST;
    h_nx   = h_wrap ? '0 : h_cnt + 1'b1;
    v_nx   = h_wrap ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;
  end
  // outputs are decoded from next-state counts so they land on the same edge as the counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      hsync  <= !H_POL;
      vsync  <= !V_POL;
      rgb_en <= 1'b1;
    end else if (en) begin
      h_cnt  <= h_nx;
      v_cnt  <= v_nx;
      hsync  <= (h_nx >= H_SS && h_nx < H_SE) ? H_POL : !H_POL;
      vsync  <= (v_nx >= V_SS && v_nx < V_SE) ? V_POL : !V_POL;
      rgb_en <= h_nx < H_ACT && v_nx < V_ACT;
    end
  assign column    = h_cnt;
  assign row       = v_cnt;
  assign line_end  = en && h_wrap;
  assign frame_end = en && h_wrap && v_wrap;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default and small-raster instances checked against a pixel-index reference model
module tb_vga_timing_gen;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic       d_hs, d_vs, d_re, d_le, d_fe, s_hs, s_vs, s_re, s_le, s_fe;
  logic [9:0] d_col, d_row, s_col, s_row;
  int n_cmp = 0, n_err = 0, p = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .en(en), .hsync(d_hs), .vsync(d_vs), .rgb_en(d_re),
    .column(d_col), .row(d_row), .line_end(d_le), .frame_end(d_fe)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(10)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .hsync(s_hs), .vsync(s_vs), .rgb_en(s_re),
    .column(s_col), .row(s_row), .line_end(s_le), .frame_end(s_fe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at p=%0d: got %0d expected %0d", tag, p, got, exp);
    end
  endtask

  // p counts enabled edges since reset; every output follows from it by raster arithmetic
  task automatic check_raster(input string tag, input int ha, hf, hs, hb, va, vf, vs, vb,
                              input bit hp, vp, input logic [9:0] c, r,
                              input logic ho, vo, re, le, fe);
    int ht, vt, x, y;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    x  = p % ht;
    y  = (p / ht) % vt;
    check({tag, " column"}, 32'(c), x);
    check({tag, " row"}, 32'(r), y);
    check({tag, " hsync"}, 32'(ho), (x >= ha + hf && x < ha + hf + hs) ? 32'(hp) : 32'(!hp));
    check({tag, " vsync"}, 32'(vo), (y >= va + vf && y < va + vf + vs) ? 32'(vp) : 32'(!vp));
    check({tag, " rgb_en"}, 32'(re), 32'(x < ha && y < va));
    check({tag, " line_end"}, 32'(le), 32'(en && x == ht - 1));
    check({tag, " frame_end"}, 32'(fe), 32'(en && x == ht - 1 && y == vt - 1));
  endtask

  task automatic check_all(input string ph);
    check_raster({ph, " def"}, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                 d_col, d_row, d_hs, d_vs, d_re, d_le, d_fe);
    check_raster({ph, " small"}, 8, 2, 3, 3, 4, 1, 1, 1, 1'b1, 1'b1,
                 s_col, s_row, s_hs, s_vs, s_re, s_le, s_fe);
  endtask

  task automatic tick(input bit e, input string ph);
    en = e;
    @(posedge clk);
    if (e) p++;
    #1;
    check_all(ph);
  endtask

  initial begin
    #34;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1700; i++) tick(1'b1, "run");
    for (int i = 0; i < 1700; i++) tick(i[0] == 1'b0, "half");
    for (int i = 0; i < 600; i++) tick($urandom_range(0, 3) != 0, "rand");
    // asynchronous reset mid-line, held across one active edge
    #3 rst = 1'b1;
    p = 0;
    #1 check_all("async_rst");
    en = 1'b1;
    @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 500; i++) tick($urandom_range(0, 2) != 0, "resume");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
